// File: rtl/vc_fifo_pkg.sv
// Shared definitions for the virtual-channel FIFO bank: default sizes,
// the clog2 helper and the encoding of the per-channel count update.
package vc_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 6;
  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int DEFAULT_NUM_VC     = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Channel-select width never collapses to zero, even for a single channel.
  function automatic int sel_width(input int num_vc);
    return (clog2(num_vc) < 1) ? 1 : clog2(num_vc);
  endfunction

  // Indexed by {wr_acc, rd_acc}.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_DEC  = 2'b01,
    CNT_INC  = 2'b10,
    CNT_BOTH = 2'b11
  } cnt_op_e;

endpackage

// File: rtl/vc_fifo_bank_if.sv
// Shared write/read port of the VC FIFO bank. The producer/consumer side
// uses the master modport and the bank uses the slave modport.
interface vc_fifo_bank_if #(
  parameter int DATA_WIDTH = vc_fifo_pkg::DEFAULT_DATA_WIDTH,
  parameter int VC_SEL_W   = 1
);
  logic                  wr_enable;
  logic [VC_SEL_W-1:0]   wr_vc;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_enable;
  logic [VC_SEL_W-1:0]   rd_vc;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;

  modport master (
    output wr_enable, wr_vc, data_in, rd_enable, rd_vc,
    input  data_out, data_out_valid
  );

  modport slave (
    input  wr_enable, wr_vc, data_in, rd_enable, rd_vc,
    output data_out, data_out_valid
  );
endinterface

// File: rtl/vc_fifo_channel.sv
// One virtual-channel FIFO: storage, pointers, occupancy, status and sticky
// errors. Acceptance is decided by the bank. Optional macro: VC_FIFO_LEVEL_EN.
module vc_fifo_channel
  import vc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr_req,
  input  logic                  i_wr_acc,
  input  logic                  i_rd_req,
  input  logic                  i_rd_acc,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [ADDR_WIDTH:0]   i_af_thresh,
  input  logic [ADDR_WIDTH:0]   i_ae_thresh,
  input  logic                  i_err_clear,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic                  o_overflow_err,
`ifdef VC_FIFO_LEVEL_EN
  output logic [ADDR_WIDTH:0]   o_cnt,
`endif
  output logic                  o_underflow_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic                  r_overflow_err;
  logic                  r_underflow_err;
  cnt_op_e               w_cnt_op;

  // NOTE: storage has no reset; emptiness is tracked by r_cnt, so clearing
  // the array would only cost a reset fan-out to every storage bit.
  always_ff @(posedge clk) begin
    if (i_wr_acc) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign w_cnt_op = cnt_op_e'({i_wr_acc, i_rd_acc});

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_cnt           <= '0;
      r_overflow_err  <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      if (i_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case (w_cnt_op)
        CNT_INC: r_cnt <= r_cnt + 1'b1;
        CNT_DEC: r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      // A fresh error in the clearing cycle still sets the bit.
      r_overflow_err  <= (r_overflow_err  & ~i_err_clear) | (i_wr_req & ~i_wr_acc);
      r_underflow_err <= (r_underflow_err & ~i_err_clear) | (i_rd_req & ~i_rd_acc);
    end
  end

  assign o_rd_data       = r_mem[r_rd_ptr];
  assign o_full          = (r_cnt == (ADDR_WIDTH+1)'(DEPTH));
  assign o_empty         = (r_cnt == '0);
  assign o_almost_full   = (r_cnt >= i_af_thresh);
  assign o_almost_empty  = (r_cnt <= i_ae_thresh);
  assign o_overflow_err  = r_overflow_err;
  assign o_underflow_err = r_underflow_err;
`ifdef VC_FIFO_LEVEL_EN
  assign o_cnt           = r_cnt;
`endif

endmodule

// File: rtl/vc_fifo_bank.sv
// Bank of NUM_VC independent FIFOs behind one write and one read port, with
// registered read data. Optional macro: VC_FIFO_LEVEL_EN adds the level port.
module vc_fifo_bank
  import vc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_VC     = DEFAULT_NUM_VC
) (
  input  logic                           clk,
  input  logic                           reset,
  vc_fifo_bank_if.slave                  bus,
  input  logic [ADDR_WIDTH:0]            af_thresh,
  input  logic [ADDR_WIDTH:0]            ae_thresh,
  input  logic                           err_clear,
  output logic [NUM_VC-1:0]              full,
  output logic [NUM_VC-1:0]              empty,
  output logic [NUM_VC-1:0]              almost_full,
  output logic [NUM_VC-1:0]              almost_empty,
  output logic [NUM_VC-1:0]              overflow_err,
`ifdef VC_FIFO_LEVEL_EN
  output logic [NUM_VC*(ADDR_WIDTH+1)-1:0] level,
`endif
  output logic [NUM_VC-1:0]              underflow_err
);

  localparam int VC_SEL_W = sel_width(NUM_VC);

  logic [NUM_VC-1:0]     w_wr_req;
  logic [NUM_VC-1:0]     w_rd_req;
  logic [NUM_VC-1:0]     w_wr_acc;
  logic [NUM_VC-1:0]     w_rd_acc;
  logic [DATA_WIDTH-1:0] w_rd_data [NUM_VC];
  logic [DATA_WIDTH-1:0] w_rd_mux;
  logic                  w_rd_any;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_out_valid;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    // An out-of-range select matches no channel, so it is silently ignored.
    assign w_wr_req[v] = bus.wr_enable && (bus.wr_vc == VC_SEL_W'(v));
    assign w_rd_req[v] = bus.rd_enable && (bus.rd_vc == VC_SEL_W'(v));
    assign w_rd_acc[v] = w_rd_req[v] && !empty[v];
    assign w_wr_acc[v] = w_wr_req[v] && (!full[v] || w_rd_acc[v]);

    vc_fifo_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_channel (
      .clk             (clk),
      .reset           (reset),
      .i_wr_req        (w_wr_req[v]),
      .i_wr_acc        (w_wr_acc[v]),
      .i_rd_req        (w_rd_req[v]),
      .i_rd_acc        (w_rd_acc[v]),
      .i_data          (bus.data_in),
      .i_af_thresh     (af_thresh),
      .i_ae_thresh     (ae_thresh),
      .i_err_clear     (err_clear),
      .o_rd_data       (w_rd_data[v]),
      .o_full          (full[v]),
      .o_empty         (empty[v]),
      .o_almost_full   (almost_full[v]),
      .o_almost_empty  (almost_empty[v]),
      .o_overflow_err  (overflow_err[v]),
`ifdef VC_FIFO_LEVEL_EN
      .o_cnt           (level[v*(ADDR_WIDTH+1) +: (ADDR_WIDTH+1)]),
`endif
      .o_underflow_err (underflow_err[v])
    );
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    w_rd_any = |w_rd_acc;
    w_rd_mux = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (w_rd_acc[v]) w_rd_mux = w_rd_data[v];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out       <= '0;
      r_data_out_valid <= 1'b0;
    end else begin
      r_data_out_valid <= w_rd_any;
      if (w_rd_any) r_data_out <= w_rd_mux;
    end
  end

  assign bus.data_out       = r_data_out;
  assign bus.data_out_valid = r_data_out_valid;

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Directed testbench for vc_fifo_bank at default parameters: hand-written
// fill/drain/wrap/reset sequences plus a table of single-cycle vectors.
module tb_vc_fifo_bank;
  import vc_fifo_pkg::*;

  logic       clk;
  logic       reset;
  logic [4:0] af_thresh;
  logic [4:0] ae_thresh;
  logic       err_clear;
  logic [1:0] full, empty, almost_full, almost_empty, overflow_err, underflow_err;
`ifdef VC_FIFO_LEVEL_EN
  logic [9:0] level;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  vc_fifo_bank_if #(.DATA_WIDTH(6), .VC_SEL_W(1)) bus ();

  vc_fifo_bank #(.DATA_WIDTH(6), .ADDR_WIDTH(4), .NUM_VC(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .af_thresh     (af_thresh),
    .ae_thresh     (ae_thresh),
    .err_clear     (err_clear),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .overflow_err  (overflow_err),
`ifdef VC_FIFO_LEVEL_EN
    .level         (level),
`endif
    .underflow_err (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr_en;
    logic       wr_vc;
    logic [5:0] din;
    logic       rd_en;
    logic       rd_vc;
    logic       clr;
    logic [4:0] af;
    logic [4:0] ae;
    logic [5:0] dout;
    logic       valid;
    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] af_o;
    logic [1:0] ae_o;
    logic [1:0] ovf;
    logic [1:0] unf;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic wvc, input logic [5:0] d,
                       input logic re, input logic rvc);
    bus.wr_enable = we;
    bus.wr_vc     = wvc;
    bus.data_in   = d;
    bus.rd_enable = re;
    bus.rd_vc     = rvc;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //          we   wvc  din    re   rvc  clr  af     ae     dout   vld  full   empty  af_o   ae_o   ovf    unf
    vecs[0]  = {1'b1,1'b0,6'h0A,1'b0,1'b0,1'b0,5'd14,5'd2, 6'h10,1'b0,2'b00,2'b10,2'b00,2'b11,2'b00,2'b00};
    vecs[1]  = {1'b1,1'b1,6'h15,1'b0,1'b0,1'b0,5'd14,5'd2, 6'h10,1'b0,2'b00,2'b00,2'b00,2'b11,2'b00,2'b00};
    vecs[2]  = {1'b1,1'b0,6'h0A,1'b1,1'b1,1'b0,5'd14,5'd2, 6'h15,1'b1,2'b00,2'b10,2'b00,2'b11,2'b00,2'b00};
    vecs[3]  = {1'b0,1'b0,6'h00,1'b1,1'b0,1'b0,5'd14,5'd2, 6'h0A,1'b1,2'b00,2'b10,2'b00,2'b11,2'b00,2'b00};
    vecs[4]  = {1'b0,1'b0,6'h00,1'b1,1'b0,1'b0,5'd14,5'd2, 6'h0A,1'b1,2'b00,2'b11,2'b00,2'b11,2'b00,2'b00};
    vecs[5]  = {1'b0,1'b0,6'h00,1'b1,1'b1,1'b0,5'd14,5'd2, 6'h0A,1'b0,2'b00,2'b11,2'b00,2'b11,2'b00,2'b10};
    vecs[6]  = {1'b0,1'b0,6'h00,1'b0,1'b0,1'b1,5'd14,5'd2, 6'h0A,1'b0,2'b00,2'b11,2'b00,2'b11,2'b00,2'b00};
    vecs[7]  = {1'b0,1'b0,6'h00,1'b1,1'b0,1'b1,5'd14,5'd2, 6'h0A,1'b0,2'b00,2'b11,2'b00,2'b11,2'b00,2'b01};
    vecs[8]  = {1'b0,1'b0,6'h00,1'b0,1'b0,1'b1,5'd14,5'd2, 6'h0A,1'b0,2'b00,2'b11,2'b00,2'b11,2'b00,2'b00};
    vecs[9]  = {1'b1,1'b0,6'h2C,1'b1,1'b0,1'b0,5'd14,5'd2, 6'h0A,1'b0,2'b00,2'b10,2'b00,2'b11,2'b00,2'b01};
    vecs[10] = {1'b0,1'b0,6'h00,1'b0,1'b0,1'b1,5'd14,5'd2, 6'h0A,1'b0,2'b00,2'b10,2'b00,2'b11,2'b00,2'b00};
    vecs[11] = {1'b0,1'b0,6'h00,1'b1,1'b0,1'b0,5'd14,5'd2, 6'h2C,1'b1,2'b00,2'b11,2'b00,2'b11,2'b00,2'b00};
    vecs[12] = {1'b0,1'b0,6'h00,1'b0,1'b0,1'b0,5'd0, 5'd0, 6'h2C,1'b0,2'b00,2'b11,2'b11,2'b11,2'b00,2'b00};
    vecs[13] = {1'b1,1'b1,6'h11,1'b0,1'b0,1'b0,5'd1, 5'd0, 6'h2C,1'b0,2'b00,2'b01,2'b10,2'b01,2'b00,2'b00};
    vecs[14] = {1'b0,1'b0,6'h00,1'b1,1'b1,1'b0,5'd14,5'd2, 6'h11,1'b1,2'b00,2'b11,2'b00,2'b11,2'b00,2'b00};

    idle();
    reset     = 1'b1;
    err_clear = 1'b0;
    af_thresh = 5'd14;
    ae_thresh = 5'd2;
    step();
    reset = 1'b0;
    check("reset_empty", empty, 2'b11);
    check("reset_full", full, 2'b00);
    check("reset_valid", bus.data_out_valid, 1'b0);
    check("reset_dout", bus.data_out, 6'h00);
    check("reset_errs", {overflow_err, underflow_err}, 4'b0000);
    check("reset_almost", {almost_full, almost_empty}, 4'b0011);

    // Fill VC0 with 1..16, then one write too many.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 1'b0, 6'(i), 1'b0, 1'b0);
      step();
      check("fill_full", full, {1'b0, i == 16});
      check("fill_af", almost_full, {1'b0, i >= 14});
      check("fill_ae", almost_empty, {1'b1, i <= 2});
    end
    drive(1'b1, 1'b0, 6'd17, 1'b0, 1'b0);
    step();
    check("ovf_set", overflow_err, 2'b01);
    check("ovf_full", full, 2'b01);
    check("ovf_valid", bus.data_out_valid, 1'b0);

    // Drain VC0: exactly 16 words 1..16, then underflow.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
      step();
      check("drain_valid", bus.data_out_valid, 1'b1);
      check("drain_data", bus.data_out, 6'(i));
      check("drain_empty", empty, {1'b1, i == 16});
    end
    step();
    check("unf_valid", bus.data_out_valid, 1'b0);
    check("unf_dout_hold", bus.data_out, 6'd16);
    check("unf_errs", {overflow_err, underflow_err}, 4'b0101);
    idle();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("clear_errs", {overflow_err, underflow_err}, 4'b0000);

    // Single-cycle vectors: interleave, error clear priority, no fall-through.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].wr_en, vecs[i].wr_vc, vecs[i].din, vecs[i].rd_en, vecs[i].rd_vc);
      err_clear = vecs[i].clr;
      af_thresh = vecs[i].af;
      ae_thresh = vecs[i].ae;
      step();
      check($sformatf("vec%0d_dout", i), bus.data_out, vecs[i].dout);
      check($sformatf("vec%0d_valid", i), bus.data_out_valid, vecs[i].valid);
      check($sformatf("vec%0d_full", i), full, vecs[i].full);
      check($sformatf("vec%0d_empty", i), empty, vecs[i].empty);
      check($sformatf("vec%0d_af", i), almost_full, vecs[i].af_o);
      check($sformatf("vec%0d_ae", i), almost_empty, vecs[i].ae_o);
      check($sformatf("vec%0d_ovf", i), overflow_err, vecs[i].ovf);
      check($sformatf("vec%0d_unf", i), underflow_err, vecs[i].unf);
    end
    idle();
    err_clear = 1'b0;
    af_thresh = 5'd14;
    ae_thresh = 5'd2;

    // Fill VC1 (pointers start at 2, so this wraps), then write+read when full.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 6'(8'h20 + i), 1'b0, 1'b0);
      step();
      check("vc1_fill_full", full, {i == 15, 1'b0});
    end
    ae_thresh = 5'd16;
    #1;
    check("ae_thresh_depth", almost_empty[1], 1'b1);
    ae_thresh = 5'd15;
    #1;
    check("ae_thresh_15", almost_empty[1], 1'b0);
    check("vc1_af", almost_full[1], 1'b1);
    ae_thresh = 5'd2;
    drive(1'b1, 1'b1, 6'h3F, 1'b1, 1'b1);
    step();
    check("full_rw_dout", bus.data_out, 6'h20);
    check("full_rw_valid", bus.data_out_valid, 1'b1);
    check("full_rw_full", full, 2'b10);
    check("full_rw_ovf", overflow_err, 2'b00);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 6'h00, 1'b1, 1'b1);
      step();
      check("wrap_data", bus.data_out, (i < 15) ? 6'(8'h21 + i) : 6'h3F);
      check("wrap_valid", bus.data_out_valid, 1'b1);
      check("wrap_empty", empty, {i == 15, 1'b1});
    end

    // Reset in the middle of traffic with VC0 holding 5 words.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 6'(8'h30 + i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 6'h00, 1'b1, 1'b1);
    step();
    drive(1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
    step();
    check("pre_rst_dout", bus.data_out, 6'h30);
    check("pre_rst_valid", bus.data_out_valid, 1'b1);
    check("pre_rst_unf", underflow_err, 2'b10);
    drive(1'b1, 1'b0, 6'h2A, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_empty", empty, 2'b11);
    check("rst_full", full, 2'b00);
    check("rst_dout", bus.data_out, 6'h00);
    check("rst_valid", bus.data_out_valid, 1'b0);
    check("rst_errs", {overflow_err, underflow_err}, 4'b0000);
    drive(1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
    step();
    check("post_rst_valid", bus.data_out_valid, 1'b0);
    check("post_rst_unf", underflow_err, 2'b01);
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
